// File: rtl/chesssoc_nios2_dbg_pkg.sv
// Shared opcodes, FSM encoding and command payload type for the Nios II
// debug access arbiter.
package chesssoc_nios2_dbg_pkg;

   localparam int unsigned OP_W        = 3;
   localparam int unsigned DATA_W      = 38;
   localparam int unsigned CMD_W       = OP_W + DATA_W;
   localparam int unsigned NUM_STROBES = 6;
   localparam int unsigned CNT_W       = 8;

   localparam logic [OP_W-1:0] OP_OCIMEM_A  = 3'd0;
   localparam logic [OP_W-1:0] OP_OCIMEM_B  = 3'd1;
   localparam logic [OP_W-1:0] OP_BREAK_A   = 3'd2;
   localparam logic [OP_W-1:0] OP_BREAK_B   = 3'd3;
   localparam logic [OP_W-1:0] OP_BREAK_C   = 3'd4;
   localparam logic [OP_W-1:0] OP_TRACECTRL = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic {
      SRC_JTAG = 1'b0,
      SRC_CPU  = 1'b1
   } src_t;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] data;
   } cmd_t;

   // True when more than one strobe bit is set.
   function automatic logic multi_hot(input logic [NUM_STROBES-1:0] v);
      return (v & (v - NUM_STROBES'(1))) != '0;
   endfunction

   // Strobe bit index equals opcode; the lowest set bit wins.
   function automatic logic [OP_W-1:0] lowest_op(input logic [NUM_STROBES-1:0] v);
      logic [OP_W-1:0] op;
      op = '0;
      for (int i = NUM_STROBES - 1; i >= 0; i--) begin
         if (v[i]) op = OP_W'(i);
      end
      return op;
   endfunction

endpackage

// File: rtl/chesssoc_nios2_dbg_cmd_fifo.sv
// First-word-fall-through command FIFO; a push while full is accepted only
// when a pop happens in the same cycle.
module chesssoc_nios2_dbg_cmd_fifo
   import chesssoc_nios2_dbg_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  cmd_t                   i_cmd,
   input  logic                   i_pop,
   output cmd_t                   o_cmd,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   cmd_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [LVL_W-1:0] w_level_nx;
   logic             r_full;
   logic             r_empty;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_pop  = i_pop && !r_empty;
   assign w_do_push = i_push && (!r_full || w_do_pop);

   always_comb begin
      w_level_nx = r_level;
      if (w_do_push && !w_do_pop)
         w_level_nx = r_level + LVL_W'(1);
      else if (!w_do_push && w_do_pop)
         w_level_nx = r_level - LVL_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_level <= w_level_nx;
         r_full  <= (w_level_nx == LVL_W'(DEPTH));
         r_empty <= (w_level_nx == '0);
      end
   end

   // Storage is not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_cmd;
   end

   assign o_cmd   = r_mem[r_rd_ptr];
   assign o_level = r_level;
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/chesssoc_nios2_gen2_0_cpu_debug_access_arbiter.sv
// Queues JTAG debug strobes and arbitrates them round-robin against CPU
// monitor requests onto the shared OCI resource port.
module chesssoc_nios2_gen2_0_cpu_debug_access_arbiter
   import chesssoc_nios2_dbg_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_W-1:0]           jdo,
   input  logic                        take_action_ocimem_a,
   input  logic                        take_action_ocimem_b,
   input  logic                        take_action_break_a,
   input  logic                        take_action_break_b,
   input  logic                        take_action_break_c,
   input  logic                        take_action_tracectrl,
   input  logic                        cpu_req,
   input  logic [OP_W-1:0]             cpu_op,
   input  logic [DATA_W-1:0]           cpu_wdata,
   output logic                        cpu_gnt,
   output logic                        cpu_done,
   output logic                        cpu_err,
   output logic                        res_start,
   output logic                        res_src,
   output logic [OP_W-1:0]             res_op,
   output logic [DATA_W-1:0]           res_wdata,
   input  logic                        res_done,
   output logic [$clog2(FIFO_DEPTH):0] q_level,
   output logic                        q_full,
   output logic                        err_collision,
   output logic                        err_overflow,
   output logic                        err_timeout,
   input  logic                        err_clr
);

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_STROBES-1:0] w_strobes;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_collision;
   logic                   w_overflow;
   cmd_t                   w_push_cmd;
   cmd_t                   w_head_cmd;
   logic [LVL_W-1:0]       w_q_level;
   logic                   w_q_full;
   logic                   w_q_empty;

   state_t                 r_state;
   state_t                 w_state_nx;
   src_t                   r_owner;
   src_t                   w_owner_nx;
   src_t                   r_last_owner;
   src_t                   w_last_owner_nx;
   src_t                   w_winner;
   logic                   w_jtag_pend;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nx;
   logic                   w_timeout;

   logic                   r_res_start;
   src_t                   r_res_src;
   logic [OP_W-1:0]        r_res_op;
   logic [DATA_W-1:0]      r_res_wdata;
   logic                   r_cpu_gnt;
   logic                   r_cpu_done;
   logic                   r_cpu_err;
   logic                   r_err_collision;
   logic                   r_err_overflow;
   logic                   r_err_timeout;

   logic                   w_start_nx;
   src_t                   w_src_nx;
   logic [OP_W-1:0]        w_op_nx;
   logic [DATA_W-1:0]      w_wdata_nx;
   logic                   w_gnt_nx;
   logic                   w_done_nx;
   logic                   w_err_nx;

   // Strobe encoder: bit position is the opcode.
   assign w_strobes = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                       take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};
   assign w_push      = |w_strobes;
   assign w_collision = multi_hot(w_strobes);
   assign w_push_cmd  = {lowest_op(w_strobes), jdo};
   assign w_pop       = (r_state == ST_ISSUE) && (r_owner == SRC_JTAG);
   assign w_overflow  = w_push && w_q_full && !w_pop;

   chesssoc_nios2_dbg_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_cmd   (w_push_cmd),
      .i_pop   (w_pop),
      .o_cmd   (w_head_cmd),
      .o_level (w_q_level),
      .o_full  (w_q_full),
      .o_empty (w_q_empty)
   );

   // Round-robin winner when both sides are pending.
   assign w_jtag_pend = !w_q_empty;

   always_comb begin
      w_winner = SRC_JTAG;
      if (w_jtag_pend && cpu_req)
         w_winner = (r_last_owner == SRC_CPU) ? SRC_JTAG : SRC_CPU;
      else if (cpu_req)
         w_winner = SRC_CPU;
   end

   always_comb begin
      w_state_nx      = r_state;
      w_owner_nx      = r_owner;
      w_last_owner_nx = r_last_owner;
      w_cnt_nx        = r_cnt;
      w_timeout       = 1'b0;
      w_start_nx      = 1'b0;
      w_src_nx        = r_res_src;
      w_op_nx         = r_res_op;
      w_wdata_nx      = r_res_wdata;
      w_done_nx       = 1'b0;
      w_err_nx        = 1'b0;
      w_gnt_nx        = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_jtag_pend || cpu_req) begin
               w_state_nx = ST_ISSUE;
               w_owner_nx = w_winner;
               w_start_nx = 1'b1;
               w_src_nx   = w_winner;
               w_cnt_nx   = '0;
               if (w_winner == SRC_JTAG) begin
                  w_op_nx    = w_head_cmd.op;
                  w_wdata_nx = w_head_cmd.data;
               end else begin
                  w_op_nx    = cpu_op;
                  w_wdata_nx = cpu_wdata;
               end
            end
         end
         ST_ISSUE: begin
            w_state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            // A completion arriving on the last allowed cycle still counts as success.
            w_cnt_nx = r_cnt + CNT_W'(1);
            if (res_done || (w_cnt_nx == CNT_W'(TIMEOUT_CYCLES))) begin
               w_state_nx = ST_DONE;
               w_timeout  = !res_done;
               w_done_nx  = (r_owner == SRC_CPU);
               w_err_nx   = (r_owner == SRC_CPU) && !res_done;
            end
         end
         ST_DONE: begin
            w_state_nx      = ST_IDLE;
            w_last_owner_nx = r_owner;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase

      w_gnt_nx = (w_owner_nx == SRC_CPU) &&
                 ((w_state_nx == ST_ISSUE) || (w_state_nx == ST_WAIT));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_owner      <= SRC_JTAG;
         r_last_owner <= SRC_CPU;
         r_cnt        <= '0;
         r_res_start  <= 1'b0;
         r_res_src    <= SRC_JTAG;
         r_res_op     <= '0;
         r_res_wdata  <= '0;
         r_cpu_gnt    <= 1'b0;
         r_cpu_done   <= 1'b0;
         r_cpu_err    <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_owner      <= w_owner_nx;
         r_last_owner <= w_last_owner_nx;
         r_cnt        <= w_cnt_nx;
         r_res_start  <= w_start_nx;
         r_res_src    <= w_src_nx;
         r_res_op     <= w_op_nx;
         r_res_wdata  <= w_wdata_nx;
         r_cpu_gnt    <= w_gnt_nx;
         r_cpu_done   <= w_done_nx;
         r_cpu_err    <= w_err_nx;
      end
   end

   // Sticky flags: a same-cycle setting event overrides err_clr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err_collision <= 1'b0;
         r_err_overflow  <= 1'b0;
         r_err_timeout   <= 1'b0;
      end else begin
         r_err_collision <= w_collision | (r_err_collision & ~err_clr);
         r_err_overflow  <= w_overflow  | (r_err_overflow  & ~err_clr);
         r_err_timeout   <= w_timeout   | (r_err_timeout   & ~err_clr);
      end
   end

   assign res_start     = r_res_start;
   assign res_src       = r_res_src;
   assign res_op        = r_res_op;
   assign res_wdata     = r_res_wdata;
   assign cpu_gnt       = r_cpu_gnt;
   assign cpu_done      = r_cpu_done;
   assign cpu_err       = r_cpu_err;
   assign q_level       = w_q_level;
   assign q_full        = w_q_full;
   assign err_collision = r_err_collision;
   assign err_overflow  = r_err_overflow;
   assign err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_chesssoc_nios2_gen2_0_cpu_debug_access_arbiter.sv
// Scoreboard bench for the debug access arbiter: expected transactions are
// queued as stimulus is driven and popped on each res_start.
module tb_chesssoc_nios2_gen2_0_cpu_debug_access_arbiter;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TO    = 8;

   localparam logic [37:0] J0   = 38'h01_1111_1111;
   localparam logic [37:0] J1   = 38'h02_2222_2222;
   localparam logic [37:0] J2   = 38'h03_3333_3333;
   localparam logic [37:0] CW   = 38'h15_ABCD_0123;
   localparam logic [37:0] CX   = 38'h3F_0F0F_F0F0;
   localparam logic [37:0] JB   = 38'h10_0000_0100;
   localparam logic [37:0] JCOL = 38'h22_C011_1DE5;
   localparam logic [37:0] JR   = 38'h05_5555_0000;
   localparam logic [37:0] JN   = 38'h0A_BEEF_CAFE;

   logic        clk = 1'b0;
   logic        reset;
   logic [37:0] jdo;
   logic        ta_oa, ta_ob, ta_ba, ta_bb, ta_bc, ta_tc;
   logic        cpu_req;
   logic [2:0]  cpu_op;
   logic [37:0] cpu_wdata;
   logic        cpu_gnt, cpu_done, cpu_err;
   logic        res_start, res_src;
   logic [2:0]  res_op;
   logic [37:0] res_wdata;
   logic        res_done;
   logic [2:0]  q_level;
   logic        q_full, err_collision, err_overflow, err_timeout, err_clr;

   typedef struct {
      logic        src;
      logic [2:0]  op;
      logic [37:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks;
   int   n_errors;
   int   n_cpu_done;
   int   cpu_left;
   logic exp_cpu_err;
   logic auto_done;

   always #5 clk = ~clk;

   chesssoc_nios2_gen2_0_cpu_debug_access_arbiter #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .jdo                   (jdo),
      .take_action_ocimem_a  (ta_oa),
      .take_action_ocimem_b  (ta_ob),
      .take_action_break_a   (ta_ba),
      .take_action_break_b   (ta_bb),
      .take_action_break_c   (ta_bc),
      .take_action_tracectrl (ta_tc),
      .cpu_req               (cpu_req),
      .cpu_op                (cpu_op),
      .cpu_wdata             (cpu_wdata),
      .cpu_gnt               (cpu_gnt),
      .cpu_done              (cpu_done),
      .cpu_err               (cpu_err),
      .res_start             (res_start),
      .res_src               (res_src),
      .res_op                (res_op),
      .res_wdata             (res_wdata),
      .res_done              (res_done),
      .q_level               (q_level),
      .q_full                (q_full),
      .err_collision         (err_collision),
      .err_overflow          (err_overflow),
      .err_timeout           (err_timeout),
      .err_clr               (err_clr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic set_strobes(input logic [5:0] s);
      {ta_tc, ta_bc, ta_bb, ta_ba, ta_ob, ta_oa} = s;
   endtask

   task automatic expect_txn(input logic src, input logic [2:0] op, input logic [37:0] d);
      exp_t e;
      e.src  = src;
      e.op   = op;
      e.data = d;
      sb.push_back(e);
   endtask

   // Advance one cycle and play the CPU side: drop cpu_req once its last cpu_done is seen.
   task automatic step();
      @(posedge clk);
      #1;
      if (cpu_done) begin
         n_cpu_done++;
         check("cpu_err", 64'(cpu_err), 64'(exp_cpu_err));
         if (cpu_left > 0) cpu_left--;
         if (cpu_left == 0) cpu_req = 1'b0;
      end else if (cpu_err) begin
         check("cpu_err_without_done", 64'(cpu_err), 64'd0);
      end
   endtask

   task automatic drain(input int max_cycles);
      int i;
      i = 0;
      while (sb.size() != 0 && i < max_cycles) begin
         step();
         i++;
      end
      check("drain_sb_empty", 64'(sb.size()), 64'd0);
      repeat (4) step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"}, 64'({res_start, res_src, res_op, cpu_gnt, cpu_done, cpu_err,
                                q_level, q_full, err_collision, err_overflow, err_timeout}), 64'd0);
      check({tag, "_wdata"}, 64'(res_wdata), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      step();
   endtask

   // Monitor: every issued transaction must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset && res_start) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_start", 64'(sb.size()), 64'd1);
         end else begin
            mon_e = sb.pop_front();
            check("mon_src",   64'(res_src),   64'(mon_e.src));
            check("mon_op",    64'(res_op),    64'(mon_e.op));
            check("mon_wdata", 64'(res_wdata), 64'(mon_e.data));
            check("mon_gnt",   64'(cpu_gnt),   64'(mon_e.src));
         end
      end
   end

   // Resource model: completes two cycles after each observed start when enabled.
   initial begin
      res_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (auto_done && res_start) begin
            repeat (2) @(posedge clk);
            #1 res_done = 1'b1;
            @(posedge clk);
            #1 res_done = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      n_cpu_done  = 0;
      cpu_left    = 0;
      exp_cpu_err = 1'b0;
      auto_done   = 1'b0;
      reset       = 1'b1;
      jdo         = '0;
      set_strobes(6'b0);
      cpu_req     = 1'b0;
      cpu_op      = '0;
      cpu_wdata   = '0;
      err_clr     = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;
      step();

      // Single JTAG command: start two cycles after the strobe.
      auto_done = 1'b1;
      jdo = 38'h2A_DEAD_BEEF;
      set_strobes(6'b001000);
      expect_txn(1'b0, 3'd3, jdo);
      check("t1_start_n", 64'(res_start), 64'd0);
      step();
      set_strobes(6'b0);
      check("t1_level_n1", 64'(q_level), 64'd1);
      check("t1_start_n1", 64'(res_start), 64'd0);
      step();
      check("t1_start_n2", 64'(res_start), 64'd1);
      check("t1_op_n2", 64'(res_op), 64'd3);
      check("t1_src_n2", 64'(res_src), 64'd0);
      check("t1_wdata_n2", 64'(res_wdata), 64'h2A_DEAD_BEEF);
      check("t1_level_n2", 64'(q_level), 64'd1);
      step();
      check("t1_level_n3", 64'(q_level), 64'd0);
      check("t1_start_n3", 64'(res_start), 64'd0);
      drain(40);

      // Contention after reset: JTAG first, then strict alternation.
      do_reset();
      auto_done  = 1'b1;
      n_cpu_done = 0;
      jdo = J0;
      set_strobes(6'b000001);
      expect_txn(1'b0, 3'd0, J0);
      expect_txn(1'b1, 3'd5, CW);
      expect_txn(1'b0, 3'd1, J1);
      expect_txn(1'b1, 3'd5, CW);
      expect_txn(1'b0, 3'd4, J2);
      expect_txn(1'b1, 3'd5, CW);
      step();
      jdo = J1;
      set_strobes(6'b000010);
      cpu_req     = 1'b1;
      cpu_op      = 3'd5;
      cpu_wdata   = CW;
      cpu_left    = 3;
      exp_cpu_err = 1'b0;
      step();
      jdo = J2;
      set_strobes(6'b010000);
      step();
      set_strobes(6'b0);
      drain(200);
      check("t2_cpu_dones", 64'(n_cpu_done), 64'd3);
      check("t2_level", 64'(q_level), 64'd0);

      // CPU timeout with a reserved opcode, overflow while busy.
      auto_done   = 1'b0;
      n_cpu_done  = 0;
      cpu_req     = 1'b1;
      cpu_op      = 3'd7;
      cpu_wdata   = CX;
      cpu_left    = 1;
      exp_cpu_err = 1'b1;
      expect_txn(1'b1, 3'd7, CX);
      step();
      check("t3_gnt_issue", 64'(cpu_gnt), 64'd1);
      step();
      auto_done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         jdo = JB + 38'(k);
         set_strobes(6'(1 << k));
         if (k < 4) expect_txn(1'b0, 3'(k), jdo);
         step();
         if (k == 3) begin
            check("t3_level_4", 64'(q_level), 64'd4);
            check("t3_full_4", 64'(q_full), 64'd1);
            check("t3_ovf_before", 64'(err_overflow), 64'd0);
         end
      end
      set_strobes(6'b0);
      check("t3_ovf_after", 64'(err_overflow), 64'd1);
      check("t3_level_after", 64'(q_level), 64'd4);
      check("t3_gnt_wait", 64'(cpu_gnt), 64'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("t3_ovf_cleared", 64'(err_overflow), 64'd0);
      begin
         int i;
         i = 0;
         while (n_cpu_done == 0 && i < 30) begin
            step();
            i++;
         end
      end
      check("t3_cpu_done_seen", 64'(n_cpu_done), 64'd1);
      check("t3_err_timeout", 64'(err_timeout), 64'd1);
      check("t3_gnt_done", 64'(cpu_gnt), 64'd0);
      drain(200);
      check("t3_level_drained", 64'(q_level), 64'd0);
      check("t3_timeout_sticky", 64'(err_timeout), 64'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("t3_timeout_cleared", 64'(err_timeout), 64'd0);

      // Two strobes in one cycle: lowest opcode kept.
      jdo = JCOL;
      set_strobes(6'b100001);
      expect_txn(1'b0, 3'd0, JCOL);
      step();
      set_strobes(6'b0);
      check("t4_collision", 64'(err_collision), 64'd1);
      check("t4_level", 64'(q_level), 64'd1);
      check("t4_no_ovf", 64'(err_overflow), 64'd0);
      drain(40);

      // Reset in WAIT with three commands queued.
      auto_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         jdo = JR + 38'(k);
         set_strobes(6'b000010);
         if (k == 0) expect_txn(1'b0, 3'd1, jdo);
         step();
      end
      set_strobes(6'b0);
      check("t5_level_3", 64'(q_level), 64'd3);
      check("t5_sb_issued", 64'(sb.size()), 64'd0);
      reset = 1'b1;
      #1;
      check_reset_outputs("t5_async");
      step();
      check_reset_outputs("t5_held");
      reset = 1'b0;
      step();
      auto_done = 1'b1;
      jdo = JN;
      set_strobes(6'b001000);
      expect_txn(1'b0, 3'd3, JN);
      step();
      set_strobes(6'b0);
      check("t5_new_level", 64'(q_level), 64'd1);
      drain(40);
      check("t5_final_level", 64'(q_level), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
